// File: rtl/hack_pkg.sv
// Shared constants and state type for the Hack instruction-fetch unit.
package hack_pkg;
   localparam int HACK_AW       = 15;
   localparam int HACK_DW       = 16;
   localparam int HACK_RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/hack_fetch_pc_counter.sv
// Program counter register: asynchronous reset, load has priority over increment,
// increment wraps modulo 2^AW.
module pc_counter #(
   parameter int            AW        = 15,
   parameter logic [AW-1:0] RESET_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          inc_i,
   input  logic [AW-1:0] load_val_i,
   output logic [AW-1:0] q_o
);
   logic [AW-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load_i)
         q_d = load_val_i;
      else if (inc_i)
         q_d = q_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_q <= RESET_VAL;
      else
         q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: owns the PC, reads the ROM over req/ack and hands
// each instruction to decode over valid/ready; jumps redirect the stream.
module hack_fetch
   import hack_pkg::*;
#(
   parameter int            AW       = HACK_AW,
   parameter int            DW       = HACK_DW,
   parameter logic [AW-1:0] RESET_PC = AW'(HACK_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          rom_req,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_ack,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          jmp,
   input  logic [AW-1:0] jmp_addr,
   output logic [AW-1:0] pc
);
   fetch_state_t  state_q, state_d;
   logic          flush_q, flush_d;
   logic          rom_req_q, rom_req_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [DW-1:0] instr_q, instr_d;
   logic [AW-1:0] instr_pc_q, instr_pc_d;
   logic          valid_q, valid_d;
   logic          pc_inc;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] next_addr;

   pc_counter #(
      .AW        (AW),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (jmp),
      .inc_i      (pc_inc),
      .load_val_i (jmp_addr),
      .q_o        (pc_q)
   );

   // A jump in the same cycle as a new request must already steer that request.
   assign next_addr = jmp ? jmp_addr : pc_q;

   always_comb begin
      state_d    = state_q;
      flush_d    = flush_q;
      rom_req_d  = rom_req_q;
      rom_addr_d = rom_addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      pc_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d    = FETCH;
               rom_req_d  = 1'b1;
               rom_addr_d = next_addr;
            end
         end
         FETCH: begin
            if (rom_ack) begin
               if (jmp || flush_q) begin
                  // Stale data: re-issue at the latest target without dropping req.
                  flush_d    = 1'b0;
                  rom_addr_d = next_addr;
               end else begin
                  instr_d    = rom_data;
                  instr_pc_d = rom_addr_q;
                  valid_d    = 1'b1;
                  pc_inc     = 1'b1;
                  rom_req_d  = 1'b0;
                  state_d    = HOLD;
               end
            end else if (jmp) begin
               flush_d = 1'b1;
            end
         end
         HOLD: begin
            if (jmp || instr_ready) begin
               valid_d = 1'b0;
               if (en) begin
                  state_d    = FETCH;
                  rom_req_d  = 1'b1;
                  rom_addr_d = next_addr;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flush_q    <= 1'b0;
         rom_req_q  <= 1'b0;
         rom_addr_q <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_q    <= flush_d;
         rom_req_q  <= rom_req_d;
         rom_addr_q <= rom_addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   assign rom_req     = rom_req_q;
   assign rom_addr    = rom_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
endmodule
